// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI_master among N_REQ requesters.
// Optional START/XFER watchdog is compiled in with `define SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 SPI_reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_msb,
    input  logic [2*N_REQ-1:0]   req_div,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 SPI_start,
    output logic [7:0]           SPI_data_trans,
    output logic                 SPI_MSB,
    output logic [1:0]           SPI_div,
    input  logic                 SPI_flag,
    input  logic [7:0]           SPI_data_rec,
    output logic [1:0]           dbg_state
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [7:0]    data_q, data_d;
    logic          msb_q, msb_d;
    logic [1:0]    div_q, div_d;
    logic          sync1_q, flag_s_q;
    logic          err_q;
    logic          tmo_hit;
    logic          gnt_found;
    logic [PW-1:0] gnt_idx, cand_idx;

    // SPI_flag comes from the sck domain; only the second flop is ever looked at.
    always_ff @(posedge clk) begin
        if (!SPI_reset) begin
            sync1_q  <= 1'b0;
            flag_s_q <= 1'b0;
        end else begin
            sync1_q  <= SPI_flag;
            flag_s_q <= sync1_q;
        end
    end

    // Search from ptr+1 upward with wrap, so the last winner has lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand_idx  = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = PW'((int'(ptr_q) + k) % N_REQ);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_d;

    assign tmo_cnt_d = (state_q == ST_START || state_q == ST_XFER) ? tmo_cnt_q + 16'd1 : 16'd0;
    assign tmo_hit   = (state_q == ST_START || state_q == ST_XFER) &&
                       (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
    assign err_d     = tmo_hit ? 1'b1 : ((state_q == ST_RESP) ? 1'b0 : err_q);

    always_ff @(posedge clk) begin
        if (!SPI_reset) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
`else
    // Keeps the parameter referenced when the watchdog is compiled out.
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign tmo_hit            = 1'b0;
    assign err_q              = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!SPI_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(N_REQ - 1);
            data_q  <= '0;
            msb_q   <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            msb_q   <= msb_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        msb_d     = msb_q;
        div_d     = div_q;
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        SPI_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (SPI_reset && gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    ptr_d   = gnt_idx;
                    data_d  = req_data[{gnt_idx, 3'b000} +: 8];
                    msb_d   = req_msb[gnt_idx];
                    div_d   = req_div[{gnt_idx, 1'b0} +: 2];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Start drops the same cycle flag_s is seen, so the master cannot re-arm.
                if (tmo_hit) begin
                    state_d = ST_RESP;
                end else if (flag_s_q) begin
                    state_d = ST_XFER;
                end else begin
                    SPI_start = 1'b1;
                end
            end
            ST_XFER: begin
                if (tmo_hit || !flag_s_q) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[ptr_q] = 1'b1;
                rsp_err          = err_q;
                rsp_data         = err_q ? 8'h00 : SPI_data_rec;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy           = (state_q != ST_IDLE);
    assign SPI_data_trans = data_q;
    assign SPI_MSB        = msb_q;
    assign SPI_div        = div_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: behavioural echo SPI_master, scoreboard of expected responses.
// The timeout scenario is included when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_txn_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk;
    logic           SPI_reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_msb;
    logic [2*N-1:0] req_div;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
    logic           rsp_err;
    logic           busy;
    logic           SPI_start;
    logic [7:0]     SPI_data_trans;
    logic           SPI_MSB;
    logic [1:0]     SPI_div;
    logic           SPI_flag;
    logic [7:0]     SPI_data_rec;
    logic [1:0]     dbg_state;

    spi_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .clk            (clk),
        .SPI_reset      (SPI_reset),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_msb        (req_msb),
        .req_div        (req_div),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .SPI_start      (SPI_start),
        .SPI_data_trans (SPI_data_trans),
        .SPI_MSB        (SPI_MSB),
        .SPI_div        (SPI_div),
        .SPI_flag       (SPI_flag),
        .SPI_data_rec   (SPI_data_rec),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];          // {err, idx[2:0], data[7:0]}
    int n_grants = 0, n_starts = 0, n_xfer = 0, stab_err = 0;
    int grant_cyc = 0, last_rsp_cyc = -10, last_lat = 0;
    int hold0 = 0;
    logic hold_low = 1'b0;
    logic [1:0] last_div = 2'b00;
    logic       last_msb = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_ent(input logic err, input int idx, input logic [7:0] d);
        return {err, 3'(idx), d};
    endfunction

    // ---------------- behavioural SPI_master with echoing slave ----------------
    initial begin : spi_model
        logic [7:0] tx;
        int         d;
        logic       ok;
        SPI_flag     = 1'b0;
        SPI_data_rec = 8'h00;
        forever begin
            @(negedge clk);
            if (SPI_reset && SPI_start && !hold_low) begin
                tx       = SPI_data_trans;
                d        = int'(SPI_div);
                last_div = SPI_div;
                last_msb = SPI_MSB;
                ok       = 1'b1;
                n_xfer++;
                for (int c = 0; c < 2 && ok; c++) begin
                    @(negedge clk);
                    if (!SPI_reset) ok = 1'b0;
                end
                if (ok) SPI_flag = 1'b1;
                for (int c = 0; c < 16 * (d + 1) && ok; c++) begin
                    @(negedge clk);
                    if (!SPI_reset) ok = 1'b0;
                end
                SPI_flag = 1'b0;
                if (ok) SPI_data_rec = tx;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        prev_start = 1'b0;
        logic        prev_busy  = 1'b0;
        logic [10:0] prev_pay   = '0;
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (SPI_start && !prev_start) n_starts++;
            prev_start = SPI_start;
            if (busy && prev_busy && ({SPI_data_trans, SPI_MSB, SPI_div} != prev_pay)) stab_err++;
            prev_busy = busy;
            prev_pay  = {SPI_data_trans, SPI_MSB, SPI_div};
            if (req_ready != '0) begin
                check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                check("ready_only_idle", 32'(busy), 32'd0);
                check("ready_after_rsp_gap", 32'(cyc > last_rsp_cyc), 32'd1);
                grant_cyc = cyc;
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_idx", 32'(rsp_valid), 32'd1 << e[10:8]);
                    check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
                    check("rsp_err", 32'(rsp_err), 32'(e[11]));
                end
                last_rsp_cyc = cyc;
                last_lat     = cyc - grant_cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle: sample ready mid-cycle, retire granted requests just after the edge.
    task automatic step();
        logic [N-1:0] r;
        @(negedge clk);
        r = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                n_grants++;
                if (i == 0 && hold0 > 1) begin
                    hold0--;
                end else begin
                    req_valid[i] = 1'b0;
                    if (i == 0) hold0 = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        SPI_reset = 1'b0;
        step();
        SPI_reset = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic m, input logic [1:0] dv);
        req_data[8*i +: 8] = d;
        req_msb[i]         = m;
        req_div[2*i +: 2]  = dv;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || req_valid != '0 || exp_q.size() != 0) && n < 1500) begin
            step();
            n++;
        end
        check({name, "_done_in_budget"}, 32'(n < 1500), 32'd1);
        repeat (3) step();
    endtask

    task automatic wait_grants(input int target);
        int n = 0;
        while (n_grants < target && n < 1500) begin
            step();
            n++;
        end
        check("grant_in_budget", 32'(n < 1500), 32'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin : main
        int g0, s0, x0, n;
        SPI_reset = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_msb   = '0;
        req_div   = '0;
        repeat (3) step();
        check("reset_outputs", 32'({req_ready, rsp_valid, rsp_data, rsp_err, busy, SPI_start,
                                    SPI_data_trans, SPI_MSB, SPI_div}), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        SPI_reset = 1'b1;
        step();

        // 1: single request
        g0 = n_grants; s0 = n_starts; x0 = n_xfer;
        set_req(0, 8'hA5, 1'b1, 2'b00);
        exp_q.push_back(exp_ent(1'b0, 0, 8'hA5));
        req_valid[0] = 1'b1;
        wait_idle("t1");
        check("t1_grants", 32'(n_grants - g0), 32'd1);
        check("t1_starts", 32'(n_starts - s0), 32'd1);
        check("t1_xfers", 32'(n_xfer - x0), 32'd1);
        check("t1_busy_low", 32'(busy), 32'd0);

        // 2: contention from reset, then 1 and 3 re-raised while 3 is served
        do_reset();
        g0 = n_grants; s0 = n_starts;
        set_req(0, 8'h11, 1'b1, 2'b00);
        set_req(1, 8'h22, 1'b1, 2'b00);
        set_req(2, 8'h33, 1'b1, 2'b00);
        set_req(3, 8'h44, 1'b1, 2'b00);
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_ent(1'b0, i, 8'h11 * (i + 1)));
        req_valid = 4'b1111;
        wait_grants(g0 + 4);
        set_req(1, 8'h55, 1'b1, 2'b00);
        set_req(3, 8'h66, 1'b1, 2'b00);
        exp_q.push_back(exp_ent(1'b0, 1, 8'h55));
        exp_q.push_back(exp_ent(1'b0, 3, 8'h66));
        req_valid = req_valid | 4'b1010;
        wait_idle("t2");
        check("t2_starts", 32'(n_starts - s0), 32'd6);

        // 3: LSB first, slowest divider
        set_req(2, 8'h3C, 1'b0, 2'b11);
        exp_q.push_back(exp_ent(1'b0, 2, 8'h3C));
        req_valid[2] = 1'b1;
        wait_idle("t3");
        check("t3_div_at_master", 32'(last_div), 32'd3);
        check("t3_msb_at_master", 32'(last_msb), 32'd0);
        check("t3_div_out", 32'(SPI_div), 32'd3);

        // 4: requester 0 held for four back-to-back transactions
        g0 = n_grants; s0 = n_starts; x0 = n_xfer;
        set_req(0, 8'h5A, 1'b1, 2'b01);
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_ent(1'b0, 0, 8'h5A));
        hold0 = 4;
        req_valid[0] = 1'b1;
        wait_idle("t4");
        check("t4_grants", 32'(n_grants - g0), 32'd4);
        check("t4_starts", 32'(n_starts - s0), 32'd4);
        check("t4_xfers", 32'(n_xfer - x0), 32'd4);

`ifdef SPI_ARB_TIMEOUT_EN
        // 5: master never raises its flag
        hold_low = 1'b1;
        s0 = n_starts;
        set_req(1, 8'hF0, 1'b1, 2'b00);
        exp_q.push_back(exp_ent(1'b1, 1, 8'h00));
        req_valid[1] = 1'b1;
        wait_idle("t5");
        check("t5_latency", 32'(last_lat), 32'(TMO + 1));
        check("t5_starts", 32'(n_starts - s0), 32'd1);
        check("t5_start_low", 32'(SPI_start), 32'd0);
        hold_low = 1'b0;
`endif

        // 6: reset mid-transfer, then requester 0 must win over 1
        set_req(0, 8'h77, 1'b1, 2'b10);
        req_valid[0] = 1'b1;
        n = 0;
        while (!(dbg_state == 2'd2 && SPI_flag) && n < 500) begin
            step();
            n++;
        end
        check("t6_reached_xfer", 32'(n < 500), 32'd1);
        repeat (3) step();
        do_reset();
        check("t6_outputs_zero", 32'({req_ready, rsp_valid, rsp_data, rsp_err, busy, SPI_start,
                                      SPI_data_trans, SPI_MSB, SPI_div}), 32'd0);
        check("t6_state_idle", 32'(dbg_state), 32'd0);
        repeat (5) step();
        set_req(0, 8'h81, 1'b1, 2'b00);
        set_req(1, 8'h92, 1'b0, 2'b00);
        exp_q.push_back(exp_ent(1'b0, 0, 8'h81));
        exp_q.push_back(exp_ent(1'b0, 1, 8'h92));
        req_valid = 4'b0011;
        wait_idle("t6");

        check("payload_stable", 32'(stab_err), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
Round-robin arbiter and sequencer that shares one SPI_master instance among N_REQ requesters. It accepts a byte request (data, bit order, clock divider), drives the master's SPI_start handshake, and tracks SPI_flag through the transfer. When the transfer ends it returns SPI_data_rec to the granted requester with a one-cycle response pulse. It sits between the on-chip clients and SPI_master, in the system clk domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 1024, clk cycles allowed in START+XFER before abort (used only with SPI_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock; same clock that feeds SPI_master
SPI_reset  in  1  synchronous, active-low reset
req_valid  in  N_REQ  per-requester request; held until req_ready
req_data  in  8*N_REQ  byte to send; slice i = [8i+7:8i]
req_msb  in  N_REQ  1 = MSB first for requester i
req_div  in  2*N_REQ  SPI_div code for requester i
req_ready  out  N_REQ  one-hot, 1-cycle accept pulse
rsp_valid  out  N_REQ  one-hot, 1-cycle response pulse
rsp_data  out  8  received byte, valid while rsp_valid != 0
rsp_err  out  1  timeout flag, qualified by rsp_valid
busy  out  1  1 whenever state != IDLE
SPI_start  out  1  to SPI_master
SPI_data_trans  out  8  to SPI_master
SPI_MSB  out  1  to SPI_master
SPI_div  out  2  to SPI_master
SPI_flag  in  1  from SPI_master (sck domain)
SPI_data_rec  in  8  from SPI_master

Behaviour:
- Reset, with SPI_reset=0 at posedge clk: state=IDLE; all outputs 0; rr pointer=N_REQ-1, so requester 0 has first priority; payload regs and synchronizer cleared. Reset mid-transfer aborts silently with no rsp_valid. SPI_master is reset by the same net.
- SPI_flag passes through a 2-flop synchronizer to flag_s. Only flag_s is used.
- States: IDLE, START, XFER, RESP.
- IDLE: if any req_valid, pick the first set bit searching from ptr+1 upward, wrapping N_REQ-1 -> 0.
  - Same cycle: pulse req_ready[g] and latch req_data/msb/div of g into payload regs.
  - Set ptr=g and go to START.
- START: SPI_start=1. SPI_data_trans, SPI_MSB and SPI_div are driven from the payload regs.
  - Stay until flag_s==1.
  - Then SPI_start=0 and go to XFER. Start is never held past flag_s rising, which prevents a retransmit.
- XFER: stay while flag_s==1. On flag_s==0 go to RESP.
- RESP, one cycle: rsp_valid[g]=1, rsp_data=SPI_data_rec, rsp_err=0. Next state is IDLE.
- Payload outputs (SPI_data_trans/MSB/div) stay constant from START entry to RESP exit and hold their last value in IDLE. SPI_div never changes mid-transfer.
- Minimum gap between transactions is 1 IDLE cycle. A new grant can occur in the cycle after RESP.
- A requester deasserting req_valid before ready is simply not granted; this is legal. Simultaneous requests are served strictly round-robin, with no starvation.
- Latency, SPI_div=00: START exit takes about 2 sck + 2 sync cycles. Total is bounded by (11 sck periods + 4) clk.

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined: a 16-bit counter clears on START entry and increments each cycle in START/XFER.
  - At TIMEOUT_CYC-1 it forces SPI_start=0 and goes to RESP with rsp_err=1 and rsp_data=8'h00.
- Undefined: no counter. rsp_err is tied 0 and START/XFER wait indefinitely.

Test Plan:
1. Single request: req0 data=8'hA5, msb=1, div=00, slave echoes on MISO. Required: req_ready[0] pulses once, one SPI_start burst, rsp_valid[0] one cycle, rsp_data equals the echoed byte, busy returns to 0.
2. Contention: req0..req3 all valid from reset with distinct data. Required: grant order 0,1,2,3. Then, with req1 and req3 re-raised while serving 3, the next grants are 1 then 3. No overlapping SPI_start.
3. Divider/order: req2 data=8'h3C, msb=0, div=11. Required: SPI_div=11 and SPI_MSB=0 held stable START..RESP, LSB-first on MOSI, rsp_data correct.
4. Back-to-back: req0 held continuously. Required: exactly one SPI transfer per req_ready, no double send, at least 1 IDLE cycle between rsp_valid and the next req_ready.
5. Timeout (macro on, TIMEOUT_CYC=16): SPI_flag forced 0. Required: rsp_valid at START+16 cycles, rsp_err=1, rsp_data=00, SPI_start=0 afterward.
6. Reset mid-XFER: assert SPI_reset=0 for 1 clk. Required: next cycle all outputs 0, state IDLE, no rsp_valid, and the next grant goes to requester 0 first.
